// File: rtl/buf_alloc_pkg.sv
// Shared definitions for the buffer-slot allocator.
//   alloc_policy_t : slot selection policy (POL_LOWEST = 0, POL_RR = 1).
package buf_alloc_pkg;

  typedef enum logic {
    POL_LOWEST = 1'b0,
    POL_RR     = 1'b1
  } alloc_policy_t;

endpackage

// File: rtl/buf_alloc_param_if.sv
// Alloc/free bus between the slot allocator and its ingress/egress clients.
//   master : client side, drives alloc_req, free_req, free_addr.
//   slave  : allocator side, drives alloc_gnt/nack/addr, free_err, count, full, empty.
interface buf_alloc_param_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 5
);
  logic              alloc_req;
  logic              alloc_gnt;
  logic              alloc_nack;
  logic [ADDR_W-1:0] alloc_addr;
  logic              free_req;
  logic [ADDR_W-1:0] free_addr;
  logic              free_err;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output alloc_req, free_req, free_addr,
    input  alloc_gnt, alloc_nack, alloc_addr, free_err, count, full, empty
  );

  modport slave (
    input  alloc_req, free_req, free_addr,
    output alloc_gnt, alloc_nack, alloc_addr, free_err, count, full, empty
  );
endinterface

// File: rtl/buf_alloc_pick.sv
// Combinational rotate-start priority encoder.
//   busy  : per-slot busy bits.
//   start : first slot index to consider (must be < NBUF).
//   found : some slot is clear.
//   idx   : first clear slot at or above start, wrapping from NBUF-1 to 0.
module buf_alloc_pick #(
  parameter int unsigned NBUF   = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic [NBUF-1:0]   busy,
  input  logic [ADDR_W-1:0] start,
  output logic              found,
  output logic [ADDR_W-1:0] idx
);

  logic [NBUF-1:0] rot;
  int unsigned     off;
  int unsigned     pos;

  // Rotate so bit 0 of rot is slot 'start'; the doubled vector provides the wrap.
  assign rot = NBUF'({busy, busy} >> start);

  always_comb begin
    found = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < NBUF; i++) begin
      if (!found && !rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    pos = 32'(start) + off;
    if (pos >= NBUF) begin
      pos = pos - NBUF;
    end
    idx = ADDR_W'(pos);
  end

endmodule

// File: rtl/buf_alloc_param.sv
// Parametrised packet-buffer slot allocator.
//   clock   : rising-edge clock.
//   reset_n : asynchronous active-low reset.
//   bus     : alloc/free bus (slave side); grant, nack, address and free_err are
//             registered one-cycle responses, full/empty decode the registered count.
module buf_alloc_param
  import buf_alloc_pkg::*;
#(
  parameter int unsigned   NBUF   = 16,
  parameter int unsigned   ADDR_W = 4,
  parameter int unsigned   CNT_W  = $clog2(NBUF + 1),
  parameter alloc_policy_t POLICY = POL_LOWEST
) (
  input logic              clock,
  input logic              reset_n,
  buf_alloc_param_if.slave bus
);

  localparam int unsigned ASpan = 2 ** ADDR_W;

  logic [NBUF-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ASpan-1:0]  busy_ext;
  logic [NBUF-1:0]   alloc_mask, free_mask;
  logic [ADDR_W-1:0] start, pick_idx, addr_q;
  logic              pick_found, alloc_ok, free_ok;
  logic              gnt_q, nack_q, ferr_q;

  buf_alloc_pick #(
    .NBUF  (NBUF),
    .ADDR_W(ADDR_W)
  ) u_pick (
    .busy (busy_q),
    .start(start),
    .found(pick_found),
    .idx  (pick_idx)
  );

  if (POLICY == POL_RR) begin : g_rr
    logic [ADDR_W-1:0] rr_ptr_q;
    logic [ADDR_W-1:0] rr_next;

    assign rr_next = (pick_idx == ADDR_W'(NBUF - 1)) ? '0 : pick_idx + ADDR_W'(1);
    assign start   = rr_ptr_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rr_ptr_q <= '0;
      end else if (alloc_ok) begin
        rr_ptr_q <= rr_next;
      end
    end
  end else begin : g_lowest
    assign start = '0;
  end

  // Zero-extended view: out-of-range free addresses read as idle and flag free_err.
  assign busy_ext = ASpan'(busy_q);

  // Both decisions use pre-edge busy, so a slot freed this cycle is not re-granted yet.
  assign alloc_ok = bus.alloc_req & pick_found;
  assign free_ok  = bus.free_req & busy_ext[bus.free_addr];

  always_comb begin
    alloc_mask = alloc_ok ? (NBUF'(1) << pick_idx) : '0;
    free_mask  = free_ok ? (NBUF'(1) << bus.free_addr) : '0;
    busy_d     = (busy_q | alloc_mask) & ~free_mask;
    count_d    = count_q + CNT_W'(alloc_ok) - CNT_W'(free_ok);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
      gnt_q   <= 1'b0;
      nack_q  <= 1'b0;
      ferr_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      gnt_q   <= alloc_ok;
      nack_q  <= bus.alloc_req & ~pick_found;
      ferr_q  <= bus.free_req & ~free_ok;
      if (alloc_ok) begin
        addr_q <= pick_idx;
      end else if (bus.alloc_req) begin
        addr_q <= '0;
      end
    end
  end

  assign bus.alloc_gnt  = gnt_q;
  assign bus.alloc_nack = nack_q;
  assign bus.alloc_addr = addr_q;
  assign bus.free_err   = ferr_q;
  assign bus.count      = count_q;
  assign bus.full       = (count_q == CNT_W'(NBUF));
  assign bus.empty      = (count_q == '0);

endmodule

// File: tb/tb_buf_alloc_param.sv
// Bench for buf_alloc_param: three instances (16 slots lowest-first, 10 slots
// lowest-first, 4 slots round-robin) checked each cycle against a slot-level model.
module tb_buf_alloc_param;
  import buf_alloc_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  bit a_req  [3];
  bit f_req  [3];
  int f_addr [3];
  int total  = 0;
  int bad    = 0;
  bit cmp_en = 1'b0;

  buf_alloc_param_if #(.ADDR_W(4), .CNT_W(5)) if0 ();
  buf_alloc_param_if #(.ADDR_W(4), .CNT_W(4)) if1 ();
  buf_alloc_param_if #(.ADDR_W(2), .CNT_W(3)) if2 ();

  assign if0.alloc_req = a_req[0];
  assign if0.free_req  = f_req[0];
  assign if0.free_addr = 4'(f_addr[0]);
  assign if1.alloc_req = a_req[1];
  assign if1.free_req  = f_req[1];
  assign if1.free_addr = 4'(f_addr[1]);
  assign if2.alloc_req = a_req[2];
  assign if2.free_req  = f_req[2];
  assign if2.free_addr = 2'(f_addr[2]);

  buf_alloc_param #(.NBUF(16), .ADDR_W(4), .POLICY(POL_LOWEST)) u0 (
    .clock(clock), .reset_n(reset_n), .bus(if0)
  );
  buf_alloc_param #(.NBUF(10), .ADDR_W(4), .POLICY(POL_LOWEST)) u1 (
    .clock(clock), .reset_n(reset_n), .bus(if1)
  );
  buf_alloc_param #(.NBUF(4), .ADDR_W(2), .POLICY(POL_RR)) u2 (
    .clock(clock), .reset_n(reset_n), .bus(if2)
  );

  // Slot-level model
  int        nb     [3] = '{16, 10, 4};
  bit        rr_pol [3] = '{1'b0, 1'b0, 1'b1};
  bit [15:0] m_busy [3];
  int        m_ptr  [3];
  int        m_addr [3];
  bit        m_gnt  [3];
  bit        m_nack [3];
  bit        m_ferr [3];
  bit        m_addr_chk [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = '0;
      m_ptr[k]  = 0;
      m_addr[k] = 0;
      m_gnt[k]  = 1'b0;
      m_nack[k] = 1'b0;
      m_ferr[k] = 1'b0;
      m_addr_chk[k] = 1'b1;
    end
  endtask

  task automatic model_step(int k);
    int pick;
    int p;
    bit okf;
    pick = -1;
    if (a_req[k]) begin
      for (int i = 0; i < nb[k]; i++) begin
        p = (m_ptr[k] + i) % nb[k];
        if (pick < 0 && !m_busy[k][p]) pick = p;
      end
    end
    okf = f_req[k] && (f_addr[k] < nb[k]) && m_busy[k][f_addr[k]];
    m_gnt[k]  = a_req[k] && (pick >= 0);
    m_nack[k] = a_req[k] && (pick < 0);
    m_ferr[k] = f_req[k] && !okf;
    m_addr_chk[k] = m_gnt[k] || m_nack[k];
    if (m_gnt[k]) begin
      m_addr[k] = pick;
      m_busy[k][pick] = 1'b1;
      if (rr_pol[k]) m_ptr[k] = (pick + 1) % nb[k];
    end else if (m_nack[k]) begin
      m_addr[k] = 0;
    end
    if (okf) m_busy[k][f_addr[k]] = 1'b0;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
  end

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, bit g, bit n, int a, bit fe, int c, bit fu, bit em);
    int ec;
    ec = $countones(m_busy[k]);
    check($sformatf("u%0d.alloc_gnt", k), int'(g), int'(m_gnt[k]));
    check($sformatf("u%0d.alloc_nack", k), int'(n), int'(m_nack[k]));
    check($sformatf("u%0d.free_err", k), int'(fe), int'(m_ferr[k]));
    if (m_addr_chk[k]) check($sformatf("u%0d.alloc_addr", k), a, m_addr[k]);
    check($sformatf("u%0d.count", k), c, ec);
    check($sformatf("u%0d.full", k), int'(fu), int'(ec == nb[k]));
    check($sformatf("u%0d.empty", k), int'(em), int'(ec == 0));
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      cmp(0, if0.alloc_gnt, if0.alloc_nack, int'(if0.alloc_addr), if0.free_err,
          int'(if0.count), if0.full, if0.empty);
      cmp(1, if1.alloc_gnt, if1.alloc_nack, int'(if1.alloc_addr), if1.free_err,
          int'(if1.count), if1.full, if1.empty);
      cmp(2, if2.alloc_gnt, if2.alloc_nack, int'(if2.alloc_addr), if2.free_err,
          int'(if2.count), if2.full, if2.empty);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 3; k++) begin
      a_req[k] = 1'b0; f_req[k] = 1'b0; f_addr[k] = 0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.count", int'(if0.count), 0);
    check("rst.empty", int'(if0.empty), 1);
    check("rst.full", int'(if0.full), 0);
    check("rst.gnt", int'(if0.alloc_gnt), 0);
    check("rst.addr", int'(if0.alloc_addr), 0);
    cmp_en  = 1'b1;
    reset_n = 1'b1;

    // Fill all 16 slots lowest-first, then overflow
    a_req[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("fill.gnt", int'(if0.alloc_gnt), 1);
      check("fill.addr", int'(if0.alloc_addr), i);
    end
    check("fill.count", int'(if0.count), 16);
    check("fill.full", int'(if0.full), 1);
    tick();
    check("ovf.nack", int'(if0.alloc_nack), 1);
    check("ovf.count", int'(if0.count), 16);

    // Free slot 5 while full and allocating: nack, slot 5 granted next edge
    f_req[0] = 1'b1; f_addr[0] = 5;
    tick();
    f_req[0] = 1'b0;
    check("ff.nack", int'(if0.alloc_nack), 1);
    check("ff.ferr", int'(if0.free_err), 0);
    check("ff.count", int'(if0.count), 15);
    tick();
    check("ff.gnt", int'(if0.alloc_gnt), 1);
    check("ff.addr", int'(if0.alloc_addr), 5);
    check("ff.count2", int'(if0.count), 16);
    a_req[0] = 1'b0;

    // Free errors on the 10-slot instance: idle slot 3, out-of-range slot 12
    a_req[1] = 1'b1;
    tick(); tick();
    a_req[1] = 1'b0;
    check("fe.count0", int'(if1.count), 2);
    f_req[1] = 1'b1; f_addr[1] = 3;
    tick();
    check("fe.idle.err", int'(if1.free_err), 1);
    check("fe.idle.count", int'(if1.count), 2);
    f_addr[1] = 12;
    tick();
    check("fe.range.err", int'(if1.free_err), 1);
    check("fe.range.count", int'(if1.count), 2);
    f_addr[1] = 1;
    tick();
    f_req[1] = 1'b0;
    check("fe.ok.err", int'(if1.free_err), 0);
    check("fe.ok.count", int'(if1.count), 1);
    a_req[1] = 1'b1;
    tick();
    a_req[1] = 1'b0;
    check("fe.realloc.addr", int'(if1.alloc_addr), 1);

    // Round-robin on the 4-slot instance
    a_req[2] = 1'b1;
    tick(); check("rr.a0", int'(if2.alloc_addr), 0);
    tick(); check("rr.a1", int'(if2.alloc_addr), 1);
    a_req[2] = 1'b0; f_req[2] = 1'b1; f_addr[2] = 0;
    tick();
    f_req[2] = 1'b0; a_req[2] = 1'b1;
    check("rr.cnt1", int'(if2.count), 1);
    tick(); check("rr.a2", int'(if2.alloc_addr), 2);
    tick(); check("rr.a3", int'(if2.alloc_addr), 3);
    tick(); check("rr.wrap", int'(if2.alloc_addr), 0);
    tick(); check("rr.nack", int'(if2.alloc_nack), 1);
    check("rr.full", int'(if2.full), 1);
    a_req[2] = 1'b0;

    // Asynchronous reset in the middle of an alloc burst
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    a_req[0] = 1'b1;
    repeat (6) tick();
    check("ar.count6", int'(if0.count), 6);
    #2 reset_n = 1'b0;
    #1;
    check("ar.gnt", int'(if0.alloc_gnt), 0);
    check("ar.addr", int'(if0.alloc_addr), 0);
    check("ar.count", int'(if0.count), 0);
    check("ar.empty", int'(if0.empty), 1);
    @(negedge clock);
    #1 reset_n = 1'b1;
    tick();
    check("ar.first.gnt", int'(if0.alloc_gnt), 1);
    check("ar.first.addr", int'(if0.alloc_addr), 0);
    check("ar.first.count", int'(if0.count), 1);
    a_req[0] = 1'b0;

    // Random alloc/free mix on all instances
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 3; k++) begin
        a_req[k]  = 1'($urandom_range(0, 1));
        f_req[k]  = 1'($urandom_range(0, 1));
        f_addr[k] = int'($urandom_range(0, (k == 2) ? 3 : 15));
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      a_req[k] = 1'b0; f_req[k] = 1'b0;
    end
    tick();
    @(negedge clock);
    #1 cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
